// File: rtl/scds_seq.sv
// scds_seq: frame sequencer for the constellation de-scramble datapath.
// Counts symbols through a frame, steps the 13-bit scramble LFSR on every
// transfer inside the de-scramble window and emits a 2-bit rotation code
// alongside each transfer. The datapath only rotates and registers.
// Optional build macro: SCDS_SEQ_TIMEOUT_EN adds a stall watchdog that pulses
// err and abandons the frame after TIMEOUT_CYC cycles without a transfer.
module scds_seq #(
  parameter int FRAME_LEN   = 496,
  parameter int WIN_START   = 16,
  parameter int WIN_END     = 494,
  parameter int IDXW        = 10,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [12:0]     seed,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic            out_rdy,
  output logic [1:0]      rot,
  output logic            rot_vld,
  output logic [IDXW-1:0] idx,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HEAD  = 3'd1,
    SCRAM = 3'd2,
    TAIL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [0:12]     LFSR_INIT = 13'h1FFF;
  localparam logic [IDXW-1:0] HEAD_LAST = IDXW'(WIN_START - 1);
  localparam logic [IDXW-1:0] WIN_LAST  = IDXW'(WIN_END);
  localparam logic [IDXW-1:0] FRM_LAST  = IDXW'(FRAME_LEN - 1);

  // A mis-parameterised instance never accepts a symbol, so it cannot
  // silently produce a malformed frame.
  localparam bit CFG_OK = (FRAME_LEN > 0) && (FRAME_LEN <= (1 << IDXW)) &&
                          (WIN_START <= WIN_END) && (WIN_END < FRAME_LEN) &&
                          (TIMEOUT_CYC > 0);

  state_t          state, state_nx;
  logic [0:12]     lfsr, lfsr_nx;   // bit 0 is the MSB of the scrambler word
  logic [IDXW-1:0] idx_q, idx_nx;
  logic            fire;
  logic            tmo;

  // Two new bits per symbol: fbk1 and fbk2 are shifted in at the MSB end.
  function automatic logic [0:12] lfsr_step(input logic [0:12] l);
    logic fbk1, fbk2;
    fbk1 = l[7] ^ l[10] ^ l[11] ^ l[12];
    fbk2 = l[6] ^ l[9]  ^ l[10] ^ l[11];
    return {fbk2, fbk1, l[0:10]};
  endfunction

  assign busy    = (state == HEAD) || (state == SCRAM) || (state == TAIL);
  assign done    = (state == DONE);
  assign in_rdy  = busy & out_rdy & CFG_OK;
  assign fire    = in_vld & in_rdy;
  assign rot_vld = fire;
  assign rot     = (state == SCRAM) ? {lfsr[0], lfsr[1]} : 2'b00;
  assign idx     = idx_q;
  assign err     = tmo;

`ifdef SCDS_SEQ_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  logic [SW-1:0] stall_cnt;

  // Stall counter: cleared outside a frame and on every transfer, counts
  // busy cycles that move no symbol.
  always_ff @(posedge clk) begin
    if (!rst)             stall_cnt <= '0;
    else if (!busy || fire) stall_cnt <= '0;
    else                  stall_cnt <= stall_cnt + SW'(1);
  end

  assign tmo = busy && (stall_cnt == SW'(TIMEOUT_CYC));
`else
  assign tmo = 1'b0;
`endif

  // Frame state, scrambler and symbol index registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      lfsr  <= LFSR_INIT;
      idx_q <= '0;
    end else begin
      state <= state_nx;
      lfsr  <= lfsr_nx;
      idx_q <= idx_nx;
    end
  end

  // Next-state: symbols advance only on a transfer; abort/watchdog override all.
  always_comb begin
    state_nx = state;
    lfsr_nx  = lfsr;
    idx_nx   = idx_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          lfsr_nx  = seed;
          idx_nx   = '0;
          state_nx = (WIN_START == 0) ? SCRAM : HEAD;
        end
      end
      HEAD: begin
        if (fire) begin
          idx_nx = idx_q + 1'b1;
          if (idx_q == HEAD_LAST) state_nx = SCRAM;
        end
      end
      SCRAM: begin
        if (fire) begin
          lfsr_nx = lfsr_step(lfsr);
          idx_nx  = idx_q + 1'b1;
          if (idx_q == WIN_LAST)
            state_nx = (WIN_END == FRAME_LEN - 1) ? DONE : TAIL;
        end
      end
      TAIL: begin
        if (fire) begin
          idx_nx = idx_q + 1'b1;
          if (idx_q == FRM_LAST) state_nx = DONE;
        end
      end
      DONE: begin
        lfsr_nx  = LFSR_INIT;
        idx_nx   = '0;
        state_nx = IDLE;
      end
      default: begin
        lfsr_nx  = LFSR_INIT;
        idx_nx   = '0;
        state_nx = IDLE;
      end
    endcase
    if (abort || tmo) begin
      lfsr_nx  = LFSR_INIT;
      idx_nx   = '0;
      state_nx = IDLE;
    end
  end

endmodule
